anita4_trigger_event_buffer: RTL and testbench



---
 rtl/anita4_trigger_event_buffer.sv | 120 ++++++++++++
 tb/tb_anita4_trigger_event_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/anita4_trigger_event_buffer.sv
// Trigger event buffer: captures rising edges of trig_i into a small FWFT FIFO
// with a valid/ready read port. Optional timestamp via EVENT_BUFFER_TIMESTAMP_EN.
module anita4_trigger_event_buffer #(
  parameter int NUM_PHI    = 16,
  parameter int DEPTH_LOG2 = 2,
  parameter int TS_WIDTH   = 32
) (
  input  logic                    clk250_i,
  input  logic                    rst_n_i,
  input  logic                    trig_i,
  input  logic [2*NUM_PHI-1:0]    phi_i,
  input  logic [7:0]              count_i,
  input  logic                    clear_i,
  input  logic                    evt_ready_i,
  output logic                    evt_valid_o,
  output logic [2*NUM_PHI-1:0]    evt_phi_o,
  output logic [7:0]              evt_count_o,
  output logic [TS_WIDTH-1:0]     evt_time_o,
  output logic [15:0]             evt_seq_o,
  output logic [DEPTH_LOG2:0]     level_o,
  output logic                    full_o,
  output logic [7:0]              overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = 2 * NUM_PHI;

  logic                  trig_q;
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [15:0]           seq;
  logic [7:0]            overflow;
  logic                  empty;
  logic                  full;
  logic                  capture;
  logic                  pop;
  logic                  push;

  logic [PW-1:0]         mem_phi   [DEPTH];
  logic [7:0]            mem_count [DEPTH];
  logic [15:0]           mem_seq   [DEPTH];

  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;

  assign rd_idx  = rd_ptr[DEPTH_LOG2-1:0];
  assign wr_idx  = wr_ptr[DEPTH_LOG2-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_idx == rd_idx);
  assign capture = trig_i && !trig_q;
  assign pop     = !empty && evt_ready_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push    = capture && (!full || pop);

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trig_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      seq      <= '0;
      overflow <= '0;
    end else begin
      trig_q <= trig_i;
      if (clear_i) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= '0;
      end else begin
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          seq    <= seq + 16'd1;
        end else if (capture && overflow != 8'hFF) begin
          overflow <= overflow + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk250_i) begin
    if (push && !clear_i) begin
      mem_phi[wr_idx]   <= phi_i;
      mem_count[wr_idx] <= count_i;
      mem_seq[wr_idx]   <= seq;
    end
  end

`ifdef EVENT_BUFFER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH-1:0] mem_ts [DEPTH];

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i)
      ts <= '0;
    else
      ts <= ts + 1'b1;
  end

  always_ff @(posedge clk250_i) begin
    if (push && !clear_i)
      mem_ts[wr_idx] <= ts;
  end

  assign evt_time_o = empty ? '0 : mem_ts[rd_idx];
`else
  assign evt_time_o = '0;
`endif

  // Head data is forced to zero while empty so reset leaves clean outputs.
  assign evt_valid_o = !empty;
  assign evt_phi_o   = empty ? '0 : mem_phi[rd_idx];
  assign evt_count_o = empty ? '0 : mem_count[rd_idx];
  assign evt_seq_o   = empty ? '0 : mem_seq[rd_idx];
  assign level_o     = wr_ptr - rd_ptr;
  assign full_o      = full;
  assign overflow_o  = overflow;

endmodule

// File: tb/tb_anita4_trigger_event_buffer.sv
// Self-checking bench for anita4_trigger_event_buffer: directed scenarios plus
// randomized traffic against a queue-based event model.
module tb_anita4_trigger_event_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [31:0] phi = '0;
  logic [7:0]  count = '0;
  logic        clear = 1'b0;
  logic        ready = 1'b0;
  logic        evt_valid;
  logic [31:0] evt_phi;
  logic [7:0]  evt_count;
  logic [31:0] evt_time;
  logic [15:0] evt_seq;
  logic [2:0]  level;
  logic        full;
  logic [7:0]  overflow;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] phi;
    logic [7:0]  count;
    logic [31:0] ts;
    logic [15:0] seq;
  } evt_t;

  evt_t        m_q[$];
  logic [31:0] m_ts;
  logic [15:0] m_seq;
  int          m_ovf;
  logic        m_prev;

  anita4_trigger_event_buffer dut (
    .clk250_i(clk), .rst_n_i(rst_n), .trig_i(trig), .phi_i(phi),
    .count_i(count), .clear_i(clear), .evt_ready_i(ready),
    .evt_valid_o(evt_valid), .evt_phi_o(evt_phi), .evt_count_o(evt_count),
    .evt_time_o(evt_time), .evt_seq_o(evt_seq), .level_o(level),
    .full_o(full), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_time(input logic [31:0] t);
`ifdef EVENT_BUFFER_TIMESTAMP_EN
    return t;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ts = '0;
    m_seq = '0;
    m_ovf = 0;
    m_prev = 1'b0;
  endtask

  task automatic model_edge(input logic t, input logic [31:0] p, input logic [7:0] c,
                            input logic clr, input logic rdy);
    evt_t e;
    logic cap;
    cap = t && !m_prev;
    if (clr) begin
      m_q.delete();
      m_ovf = 0;
    end else begin
      if (rdy && m_q.size() > 0)
        void'(m_q.pop_front());
      if (cap) begin
        if (m_q.size() < DEPTH) begin
          e.phi = p; e.count = c; e.ts = m_ts; e.seq = m_seq;
          m_q.push_back(e);
          m_seq = m_seq + 16'd1;
        end else if (m_ovf < 255) begin
          m_ovf++;
        end
      end
    end
    m_prev = t;
    m_ts = m_ts + 32'd1;
  endtask

  task automatic check_model();
    chk("m_valid", 64'(evt_valid), 64'(m_q.size() > 0));
    chk("m_level", 64'(level), 64'(m_q.size()));
    chk("m_full", 64'(full), 64'(m_q.size() == DEPTH));
    chk("m_ovf", 64'(overflow), 64'(m_ovf));
    if (m_q.size() > 0) begin
      chk("m_phi", 64'(evt_phi), 64'(m_q[0].phi));
      chk("m_count", 64'(evt_count), 64'(m_q[0].count));
      chk("m_time", 64'(evt_time), 64'(exp_time(m_q[0].ts)));
      chk("m_seq", 64'(evt_seq), 64'(m_q[0].seq));
    end
  endtask

  // Called at a negedge; drives inputs, lets one rising edge pass, checks, returns at the next negedge.
  task automatic step(input logic t, input logic [31:0] p, input logic [7:0] c,
                      input logic clr, input logic rdy);
    trig = t; phi = p; count = c; clear = clr; ready = rdy;
    @(posedge clk);
    model_edge(t, p, c, clr, rdy);
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    trig = 1'b0; clear = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [15:0] exp_s;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_valid", 64'(evt_valid), 0);
    chk("rst_level", 64'(level), 0);
    chk("rst_full", 64'(full), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_phi", 64'(evt_phi), 0);

    // Single trigger at ts=100
    while (m_ts != 32'd100) step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 32'h0003_0000, 8'h05, 1'b0, 1'b0);
    chk("single_valid", 64'(evt_valid), 1);
    chk("single_phi", 64'(evt_phi), 64'h0003_0000);
    chk("single_count", 64'(evt_count), 5);
    chk("single_time", 64'(evt_time), 64'(exp_time(32'd100)));
    chk("single_seq", 64'(evt_seq), 0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("single_pop", 64'(evt_valid), 0);

    // Held trigger
    for (int i = 0; i < 10; i++) step(1'b1, 32'hA5A5_0001, 8'h11, 1'b0, 1'b0);
    chk("held_level", 64'(level), 1);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Overflow from a fresh reset
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0);
    end
    chk("ovf_level", 64'(level), 4);
    chk("ovf_full", 64'(full), 1);
    chk("ovf_count", 64'(overflow), 2);
    chk("ovf_head_seq", 64'(evt_seq), 0);

    // Full with simultaneous capture and pop
    step(1'b1, 32'hDEAD_BEEF, 8'h44, 1'b0, 1'b1);
    chk("pp_level", 64'(level), 4);
    chk("pp_head_seq", 64'(evt_seq), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("pp_drain_seq", 64'(evt_seq), 64'(i));
      step(1'b0, '0, '0, 1'b0, 1'b1);
    end
    chk("pp_empty", 64'(evt_valid), 0);

    for (int i = 0; i < 300; i++) begin
      step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0);
    end
    chk("ovf_sat", 64'(overflow), 255);

    // Clear coincident with capture; seq continues at 9
    step(1'b1, 32'h1234_5678, 8'h77, 1'b1, 1'b0);
    chk("clr_level", 64'(level), 0);
    chk("clr_ovf", 64'(overflow), 0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_00FF, 8'h01, 1'b0, 1'b0);
    exp_s = 16'd9;
    chk("clr_next_seq", 64'(evt_seq), 64'(exp_s));

    // Randomized traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 2) == 0, $urandom, 8'($urandom),
           $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0);

    // Async reset mid-burst
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0);
    end
    step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
    chk("arst_pre_valid", 64'(evt_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(evt_valid), 0);
    chk("arst_level", 64'(level), 0);
    chk("arst_full", 64'(full), 0);
    chk("arst_ovf", 64'(overflow), 0);
    chk("arst_phi", 64'(evt_phi), 0);
    chk("arst_count", 64'(evt_count), 0);
    chk("arst_seq", 64'(evt_seq), 0);
    chk("arst_time", 64'(evt_time), 0);
    trig = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0001, 8'h22, 1'b0, 1'b0);
    chk("arst_first_seq", 64'(evt_seq), 0);
    chk("arst_first_time", 64'(evt_time), 64'(exp_time(32'd5)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout compared=%0d", compared);
    $fatal(1, "timeout");
  end

endmodule
